result_seg_display: RTL and testbench
=====================================

# result_seg_display

Downstream consumer of the 4-bit `result` bus produced by the lab's combinational adder gate. It synchronizes and glitch-filters the bus, latches a stable value, converts it to two decimal digits (00–15), and drives a 2-digit, active-low, time-multiplexed 7-segment display on the board. It also emits a one-cycle update pulse whenever the shown value changes.

## Interface
Parameters:
- `SCAN_DIV`, default 100000: clock cycles per digit slot. Minimum 2.
- `STABLE`, default 4: consecutive cycles the synchronized input must hold before it is displayed. Minimum 1.

Ports:
- `clk` input 1: single system clock. All logic is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `result` input 4: unsigned value from the upstream gate. It is asynchronous or combinational relative to `clk`.
- `seg_n` output 7: active-low segments, `seg_n[6:0]` = g,f,e,d,c,b,a.
- `an_n` output 2: active-low digit enables. `an_n[0]` = ones digit, `an_n[1]` = tens digit.
- `disp_val` output 4: value currently displayed.
- `upd` output 1: one-cycle pulse when `disp_val` loads a new value.

## Operation
- **Synchronizer:** two flops, `s1` then `s2`, on `result`.
- **Filter:**
  - When `s2 != cand`: `cand <= s2` and `cnt <= 0`.
  - Otherwise `cnt` increments, saturating at `STABLE-1`.
  - When `s2 == cand` and `cnt == STABLE-1` and `cand != disp_val`: `disp_val <= cand` and `upd <= 1`.
  - In all other cycles `upd <= 0`.
- **Digit split (combinational from `disp_val`):**
  - `tens = (disp_val >= 10)`.
  - `ones = disp_val - 10*tens`.
- **Scan FSM:**
  - States: ONES and TENS.
  - `scan_cnt` counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the state toggles (ONES→TENS→ONES).
- **Drive:**
  - During `scan_cnt == 0` of every slot, `an_n = 2'b11` (ghost guard).
  - Otherwise, ONES: `an_n = 2'b10`, `seg_n = enc(ones)`.
  - Otherwise, TENS: `an_n = 2'b01`, `seg_n = enc(1)`. If `tens == 0`, `an_n = 2'b11` (leading-zero blank).
  - `seg_n` and `an_n` are registered outputs.
- **Encoding (active-low gfedcba, hex):**
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10

## Timing
- **Reset values:**
  - `seg_n = 7'h7F`, `an_n = 2'b11`, `disp_val = 0`, `upd = 0`.
  - `s1 = s2 = cand = 0`, `cnt = 0`, `scan_cnt = 0`, state = ONES.
- **Update latency:** the new value is held on `result` before edge 1.
  - Edge 1: `s1` captures it. Edge 2: `s2` captures it. Edge 3: `cand` loads and `cnt = 0`.
  - `disp_val` loads and `upd` rises at edge 3+STABLE (edge 7 with the default).
  - `upd` falls on the next edge.
- **Segment latency:** new `seg_n`/`an_n` reflect `disp_val` one edge after it loads, if the current slot is not in its guard cycle.
- **Glitches:** any change of `s2` restarts `cnt`. A value held for fewer than STABLE+1 consecutive `s2` cycles is never displayed.
- **Return to shown value:** if the input returns to the value already shown, no `upd` is issued.
- **Scan period:** 2*SCAN_DIV cycles per full refresh, independent of filter activity.
- **Reset mid-operation:** asserting `rst_n` low immediately forces all reset values. This includes blanking the display, with no dependence on `clk`. Deassertion is sampled on `clk`, and the scan restarts in ONES at `scan_cnt = 0`.

## Structure
- **Package `result_disp_pkg`:**
  - Digit-state enum (`DIG_ONES`, `DIG_TENS`).
  - Segment constants `SEG_0`..`SEG_9` and `SEG_BLANK = 7'h7F`.
  - Anode constants `AN_OFF`, `AN_ONES`, `AN_TENS`.
- **Sub-module `seg7_decode`:** 4-bit digit in, 7-bit active-low segments out, purely combinational. Inputs >9 give `SEG_BLANK`.
- **Top:** synchronizer, filter, digit split, scan FSM, output registers.

## Test plan
Benches override `SCAN_DIV=4` and `STABLE=4`.
- **Reset:** assert `rst_n=0` mid-cycle → `seg_n=7F`, `an_n=11`, `disp_val=0`, `upd=0`, asynchronously.
- **Single digit:** apply `result=9` after reset → at edge 7 `disp_val=9` with exactly one `upd` cycle. ONES slots then show `an_n=10`, `seg_n=10` on cycles 1–3 and `an_n=11` on cycle 0. TENS slots are fully blank.
- **Two digits:** apply `result=10` → TENS slot `an_n=01`, `seg_n=79`; ONES slot `an_n=10`, `seg_n=40`.
- **Glitch rejection:** hold 9 stably, then pulse 15 for 3 cycles and return to 9 → `disp_val` stays 9 and `upd` never asserts.
- **Maximum value:** apply `result=15` → display reads "15" (TENS `seg_n=79`, ONES `seg_n=12`) and `upd` pulses once.
- **Reset mid-operation:** with "15" displayed, pulse `rst_n` low for 1 cycle → display blank and `disp_val=0`. After release, "15" reappears at edge 7, with `upd` pulsing once.

Source files
------------

// File: rtl/result_disp_pkg.sv
// Shared types and constants for the 2-digit result display:
// scan-slot states, active-low gfedcba segment patterns and anode codes.
package result_disp_pkg;
  typedef enum logic {DIG_ONES = 1'b0, DIG_TENS = 1'b1} dig_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;
endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes go blank.
module seg7_decode
  import result_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);
  always_comb begin
    seg_n = SEG_BLANK;
    case (digit)
      4'd0: seg_n = SEG_0;
      4'd1: seg_n = SEG_1;
      4'd2: seg_n = SEG_2;
      4'd3: seg_n = SEG_3;
      4'd4: seg_n = SEG_4;
      4'd5: seg_n = SEG_5;
      4'd6: seg_n = SEG_6;
      4'd7: seg_n = SEG_7;
      4'd8: seg_n = SEG_8;
      4'd9: seg_n = SEG_9;
      default: seg_n = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/result_seg_display.sv
// Synchronizes and debounces the 4-bit result bus, then shows it as 00-15
// on a 2-digit multiplexed active-low 7-segment display.
module result_seg_display
  import result_disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int STABLE   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] result,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic [3:0] disp_val,
  output logic       upd
);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;

  logic [3:0]    s1, s2, cand;
  logic [CW-1:0] cnt;
  logic [SW-1:0] scan_cnt, scan_nxt;
  dig_e          state, state_nxt;
  logic          tens;
  logic [3:0]    ones;
  logic [6:0]    ones_seg, seg_d;
  logic [1:0]    an_d;

  // Two-flop synchronizer, then a stability filter: any change restarts cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      cand     <= '0;
      cnt      <= '0;
      disp_val <= '0;
      upd      <= 1'b0;
    end else begin
      s1  <= result;
      s2  <= s1;
      upd <= 1'b0;
      if (s2 != cand) begin
        cand <= s2;
        cnt  <= '0;
      end else begin
        if (cnt != CW'(STABLE - 1)) cnt <= cnt + 1'b1;
        if (cnt == CW'(STABLE - 1) && cand != disp_val) begin
          disp_val <= cand;
          upd      <= 1'b1;
        end
      end
    end
  end

  assign tens = (disp_val >= 4'd10);
  assign ones = tens ? disp_val - 4'd10 : disp_val;

  seg7_decode u_ones_dec (
    .digit (ones),
    .seg_n (ones_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= DIG_ONES;
      scan_cnt <= '0;
    end else begin
      state    <= state_nxt;
      scan_cnt <= scan_nxt;
    end
  end

  // Outputs are decoded from the next slot position so the registered
  // an_n/seg_n line up with scan_cnt; slot count 0 is the ghost guard.
  always_comb begin
    scan_nxt  = scan_cnt + 1'b1;
    state_nxt = state;
    if (scan_cnt == SW'(SCAN_DIV - 1)) begin
      scan_nxt  = '0;
      state_nxt = (state == DIG_ONES) ? DIG_TENS : DIG_ONES;
    end
    an_d  = AN_OFF;
    seg_d = SEG_BLANK;
    if (scan_nxt != '0) begin
      if (state_nxt == DIG_ONES) begin
        an_d  = AN_ONES;
        seg_d = ones_seg;
      end else if (tens) begin
        an_d  = AN_TENS;
        seg_d = SEG_1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n <= SEG_BLANK;
      an_n  <= AN_OFF;
    end else begin
      seg_n <= seg_d;
      an_n  <= an_d;
    end
  end
endmodule

// File: tb/tb_result_seg_display.sv
// Scoreboard bench for result_seg_display with SCAN_DIV=4, STABLE=4.
module tb_result_seg_display;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] result;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic [3:0] disp_val;
  logic       upd;

  int nvec = 0;
  int nerr = 0;
  int k    = 0;
  int upd_cnt = 0;
  logic [3:0] sb_q[$];

  result_seg_display #(.SCAN_DIV(4), .STABLE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .result   (result),
    .seg_n    (seg_n),
    .an_n     (an_n),
    .disp_val (disp_val),
    .upd      (upd)
  );

  always #5 clk = ~clk;

  // Edges since reset release; drives the reference scan position.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) k <= 0;
    else        k <= k + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Pop the scoreboard on every update pulse.
  always @(negedge clk) begin
    if (rst_n && upd) begin
      upd_cnt++;
      if (sb_q.size() == 0) chk("upd_unexpected", 1, 0);
      else chk("disp_val_on_upd", disp_val, sb_q.pop_front());
    end
  end

  task automatic apply(input logic [3:0] v, input bit expect_upd);
    result = v;
    if (expect_upd) sb_q.push_back(v);
  endtask

  task automatic wait_upd(input string tag);
    int lat = 99;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (upd) begin lat = i; break; end
    end
    chk(tag, lat, 7);
    @(negedge clk);
    chk("upd_falls", upd, 0);
  endtask

  // Check one full refresh period against the reference scan model.
  task automatic scan_check(input int val);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      int sc = k % 4;
      bit ts = ((k / 4) % 2) == 1;
      logic [1:0] ea = 2'b11;
      logic [6:0] es = 7'h7F;
      if (sc != 0) begin
        if (!ts) begin ea = 2'b10; es = enc(val % 10); end
        else if (val >= 10) begin ea = 2'b01; es = 7'h79; end
      end
      chk($sformatf("an_n v%0d k%0d", val, k), an_n, ea);
      chk($sformatf("seg_n v%0d k%0d", val, k), seg_n, es);
      @(negedge clk);
    end
  endtask

  initial begin
    int c0;
    rst_n = 1'b0;
    result = 4'd0;
    #12;
    chk("rst_seg", seg_n, 7'h7F);
    chk("rst_an", an_n, 2'b11);
    chk("rst_disp", disp_val, 0);
    chk("rst_upd", upd, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    scan_check(0);

    // single digit
    c0 = upd_cnt;
    apply(4'd9, 1);
    wait_upd("lat_9");
    scan_check(9);
    chk("upd_once_9", upd_cnt - c0, 1);

    // two digits
    apply(4'd10, 1);
    wait_upd("lat_10");
    scan_check(10);

    // glitch rejection around a stable 9
    apply(4'd9, 1);
    wait_upd("lat_9b");
    repeat (4) @(negedge clk);
    c0 = upd_cnt;
    apply(4'd15, 0);
    repeat (3) @(negedge clk);
    apply(4'd9, 0);
    repeat (15) @(negedge clk);
    chk("glitch_upd", upd_cnt - c0, 0);
    chk("glitch_disp", disp_val, 9);

    // maximum value
    c0 = upd_cnt;
    apply(4'd15, 1);
    wait_upd("lat_15");
    scan_check(15);
    chk("upd_once_15", upd_cnt - c0, 1);

    // asynchronous reset mid-operation
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_seg", seg_n, 7'h7F);
    chk("mid_rst_an", an_n, 2'b11);
    chk("mid_rst_disp", disp_val, 0);
    chk("mid_rst_upd", upd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    c0 = upd_cnt;
    sb_q.push_back(4'd15);
    wait_upd("lat_rst15");
    scan_check(15);
    chk("upd_once_rst", upd_cnt - c0, 1);

    chk("sb_empty", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
